dot_acc: RTL



---
 rtl/dot_acc_pkg.sv | 10 +
 rtl/dot_acc_if.sv | 13 +
 rtl/dot_acc_mult.sv | 12 +
 rtl/dot_acc.sv | 60 ++++++
 4 files changed

// File: rtl/dot_acc_pkg.sv
// dot_acc_pkg: shared widths, types and parameter checks for the dot-product datapath
package dot_acc_pkg;
  localparam int OPND_W = 4;
  localparam int PROD_W = 8;
  typedef logic [OPND_W-1:0] opnd_t;
  typedef logic [PROD_W-1:0] prod_t;
  function automatic int acc_w_min(input int len);
    return PROD_W + $clog2(len);
  endfunction
endpackage

// File: rtl/dot_acc_if.sv
// dot_acc_if: operand-pair input stream and vector-sum output stream
interface dot_acc_if #(parameter int ACC_W = 10);
  import dot_acc_pkg::*;
  logic in_valid;
  logic in_ready;
  opnd_t in_a;
  opnd_t in_b;
  logic out_valid;
  logic out_ready;
  logic [ACC_W-1:0] out_sum;
  modport master (output in_valid, in_a, in_b, out_ready, input in_ready, out_valid, out_sum);
  modport slave (input in_valid, in_a, in_b, out_ready, output in_ready, out_valid, out_sum);
endinterface

// File: rtl/dot_acc_mult.sv
// mult: 4x4 unsigned combinational array multiplier
module mult (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] s
);
  // sum of the shifted partial-product rows
  always_comb begin
    s = '0;
    for (int i = 0; i < 4; i++) s = s + ({4'b0, a & {4{b[i]}}} << i);
  end
endmodule

// File: rtl/dot_acc.sv
// dot_acc: registers 4x4 products and accumulates LEN of them into one sum per vector
module dot_acc
  import dot_acc_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int ACC_W = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  dot_acc_if.slave bus
);
  localparam int BW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [BW-1:0] LAST = BW'(LEN - 1);
  if (LEN < 1 || LEN > 256) begin : g_len_chk
    $error("dot_acc: LEN must be in 1..256");
  end
  if (ACC_W < acc_w_min(LEN)) begin : g_w_chk
    $warning("dot_acc: ACC_W narrower than products need, sums wrap");
  end
  logic [BW-1:0] beat_cnt;
  prod_t prod, p_data;
  logic p_valid, p_last, stall, accept, load;
  logic [ACC_W-1:0] acc, sum;
  assign stall = bus.out_valid && !bus.out_ready;
  assign bus.in_ready = !stall && !clr;
  assign accept = bus.in_valid && bus.in_ready;
  assign sum = acc + ACC_W'(p_data);
  assign load = p_valid && p_last && !stall && !clr;
  mult u_mult (.a(bus.in_a), .b(bus.in_b), .s(prod));
  // product register and beat position within the vector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      p_valid <= 1'b0;
      p_last <= 1'b0;
      p_data <= '0;
    end else if (!stall) begin
      p_valid <= accept;
      if (clr) beat_cnt <= '0;
      else if (accept) begin
        p_data <= prod;
        p_last <= beat_cnt == LAST;
        beat_cnt <= (beat_cnt == LAST) ? '0 : beat_cnt + 1'b1;
      end
    end
  end
  // accumulator and completed-sum output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      bus.out_valid <= 1'b0;
      bus.out_sum <= '0;
    end else if (!stall) begin
      bus.out_valid <= load;
      if (load) bus.out_sum <= sum;
      acc <= (clr || load) ? '0 : (p_valid ? sum : acc);
    end
  end
endmodule
